// File: rtl/sprite_pkg.sv
// ---------------------------------------------------------------------------
// sprite_pkg
// Shared definitions for the sprite fetch sequencer:
//   - layer count, coordinate / ROM address / colour widths
//   - fixed per-layer sprite width and height table
//   - ROM-select and tank-direction enums
//   - transparent-key and background colour constants
//   - helpers mapping a layer (and its direction) to a ROM select
// ---------------------------------------------------------------------------
package sprite_pkg;

    localparam int MAX_LAYERS  = 8;
    localparam int LAYER_IDX_W = 3;
    localparam int COORD_W     = 10;
    localparam int ROM_ADDR_W  = 19;
    localparam int RGB_W       = 24;

    // Layer map: 0 tank1, 1 tank2, 2 bullet, 3/5 wall_h, 4/6 wall_v, 7 spare.
    // Widths are powers of two so the ROM address is a shift-and-add.
    localparam int LAYER_W [MAX_LAYERS] = '{32, 32, 16, 64, 16, 64, 16, 16};
    localparam int LAYER_H [MAX_LAYERS] = '{32, 32, 16, 16, 64, 16, 64, 16};

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_e;

    typedef enum logic [2:0] {
        ROM_TANK_UP    = 3'd0,
        ROM_TANK_RIGHT = 3'd1,
        ROM_TANK_LEFT  = 3'd2,
        ROM_TANK_DOWN  = 3'd3,
        ROM_BULLET     = 3'd4,
        ROM_WALL_H     = 3'd5,
        ROM_WALL_V     = 3'd6,
        ROM_NONE       = 3'd7
    } rom_sel_e;

    localparam logic [RGB_W-1:0] KEY_TANK  = 24'hFF0000;
    localparam logic [RGB_W-1:0] KEY_OTHER = 24'hFFFFFF;
    localparam logic [RGB_W-1:0] BG_COLOUR = 24'hFFFFFF;

    typedef struct packed {
        logic               en;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        dir_e               dir;
    } layer_cfg_t;

    // Tank layers pick one of four ROMs by direction (the enum values of
    // the tank ROMs line up with the direction codes); the spare layer
    // reuses the bullet ROM.
    function automatic rom_sel_e layerRomSel(input logic [LAYER_IDX_W-1:0] layer,
                                             input dir_e dir);
        rom_sel_e sel;
        case (layer)
            3'd0, 3'd1: sel = rom_sel_e'({1'b0, dir});
            3'd2, 3'd7: sel = ROM_BULLET;
            3'd3, 3'd5: sel = ROM_WALL_H;
            default:    sel = ROM_WALL_V;
        endcase
        return sel;
    endfunction

    function automatic logic layerIsTank(input logic [LAYER_IDX_W-1:0] layer);
        return (layer == 3'd0) || (layer == 3'd1);
    endfunction

endpackage

// File: rtl/sprite_prio_arb.sv
// ---------------------------------------------------------------------------
// sprite_prio_arb
// Fixed-priority arbiter: the lowest-index asserted hit wins.
// Ports:
//   hit_i    - per-layer hit vector
//   grant_o  - one-hot grant of the winning layer (zero if no hit)
//   index_o  - binary index of the winning layer (zero if no hit)
//   any_o    - at least one layer hit
// ---------------------------------------------------------------------------
module sprite_prio_arb
    import sprite_pkg::*;
#(
    parameter int N = MAX_LAYERS
)(
    input  logic [N-1:0]           hit_i,
    output logic [N-1:0]           grant_o,
    output logic [LAYER_IDX_W-1:0] index_o,
    output logic                   any_o
);

    // Scan from the lowest priority upward so the last match written is
    // the highest-priority (lowest-index) hitting layer.
    always_comb begin
        grant_o = '0;
        index_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (hit_i[i]) begin
                grant_o    = '0;
                grant_o[i] = 1'b1;
                index_o    = LAYER_IDX_W'(i);
            end
        end
    end

    assign any_o = |hit_i;

endmodule

// File: rtl/sprite_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// sprite_fetch_sequencer
// Per-pixel sprite compositor front end: hit-tests every layer against the
// current pixel, fetches the highest-priority hit from a shared sprite ROM
// and resolves transparency into the final VGA colour. Layer configuration
// is double-buffered (shadow written any time, active loaded on frame_start).
// Ports:
//   clk_i, rst_i              - clock, asynchronous active-high reset
//   frame_start_i             - one-cycle pulse at start of vertical blank
//   pixel_valid_i             - DrawX_i/DrawY_i valid this cycle
//   DrawX_i, DrawY_i          - current pixel coordinate
//   cfg_we_i, cfg_layer_i     - shadow config write strobe and layer index
//   cfg_x_i, cfg_y_i          - sprite top-left origin
//   cfg_dir_i, cfg_en_i       - tank direction, layer visible
//   rom_addr_o, rom_sel_o     - shared sprite-ROM address and ROM select
//   rom_data_i                - ROM pixel, RGB 8:8:8, ROM_LAT cycles later
//   out_valid_o               - VGA_* carry a resolved pixel
//   VGA_R_o, VGA_G_o, VGA_B_o - resolved colour (held while out_valid_o low)
//   collide_t1_o/t2_o         - sticky bullet/tank overlap flags per frame
// ---------------------------------------------------------------------------
module sprite_fetch_sequencer
    import sprite_pkg::*;
#(
    parameter int NUM_LAYERS = MAX_LAYERS,
    parameter int ROM_LAT    = 1
)(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   frame_start_i,
    input  logic                   pixel_valid_i,
    input  logic [COORD_W-1:0]     DrawX_i,
    input  logic [COORD_W-1:0]     DrawY_i,
    input  logic                   cfg_we_i,
    input  logic [LAYER_IDX_W-1:0] cfg_layer_i,
    input  logic [COORD_W-1:0]     cfg_x_i,
    input  logic [COORD_W-1:0]     cfg_y_i,
    input  logic [1:0]             cfg_dir_i,
    input  logic                   cfg_en_i,
    output logic [ROM_ADDR_W-1:0]  rom_addr_o,
    output logic [2:0]             rom_sel_o,
    input  logic [RGB_W-1:0]       rom_data_i,
    output logic                   out_valid_o,
    output logic [7:0]             VGA_R_o,
    output logic [7:0]             VGA_G_o,
    output logic [7:0]             VGA_B_o,
    output logic                   collide_t1_o,
    output logic                   collide_t2_o
);

    layer_cfg_t shadow_q [NUM_LAYERS];
    layer_cfg_t shadow_d [NUM_LAYERS];
    layer_cfg_t active_q [NUM_LAYERS];
    layer_cfg_t active_d [NUM_LAYERS];
    layer_cfg_t cfgWord;

    assign cfgWord = '{en: cfg_en_i, x: cfg_x_i, y: cfg_y_i, dir: dir_e'(cfg_dir_i)};

    // Shadow registers take writes; active registers copy the updated shadow
    // on frame_start so a write landing in the same cycle is committed too.
    // Indices at or above NUM_LAYERS match no slot and are dropped.
    always_comb begin
        for (int i = 0; i < NUM_LAYERS; i++) begin
            shadow_d[i] = shadow_q[i];
            active_d[i] = active_q[i];
            if (cfg_we_i && (cfg_layer_i == LAYER_IDX_W'(i))) begin
                shadow_d[i] = cfgWord;
            end
            if (frame_start_i) begin
                active_d[i] = shadow_d[i];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    // Stage 0 hit test against the pre-commit active set. Relative offsets
    // wrap in 10 bits, so a pixel left of / above the origin yields a large
    // offset and fails the size compare.
    logic [NUM_LAYERS-1:0] hit;
    logic [ROM_ADDR_W-1:0] layerAddr [NUM_LAYERS];

    for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_layer
        localparam int W     = LAYER_W[g];
        localparam int H     = LAYER_H[g];
        localparam int SHIFT = $clog2(W);
        logic [COORD_W-1:0] relX;
        logic [COORD_W-1:0] relY;
        assign relX          = DrawX_i - active_q[g].x;
        assign relY          = DrawY_i - active_q[g].y;
        assign hit[g]        = active_q[g].en && (relX < COORD_W'(W)) && (relY < COORD_W'(H));
        assign layerAddr[g]  = ROM_ADDR_W'(relX) + (ROM_ADDR_W'(relY) << SHIFT);
    end

    logic [NUM_LAYERS-1:0]  grant;
    logic [LAYER_IDX_W-1:0] winIdx;
    logic                   anyHit;

    sprite_prio_arb #(
        .N(NUM_LAYERS)
    ) u_arb (
        .hit_i  (hit),
        .grant_o(grant),
        .index_o(winIdx),
        .any_o  (anyHit)
    );

    // One-hot AND-OR select of the winner's ROM address.
    logic [ROM_ADDR_W-1:0] winAddr;
    always_comb begin
        winAddr = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            winAddr = winAddr | (layerAddr[i] & {ROM_ADDR_W{grant[i]}});
        end
    end

    // Stage 1 fetch request plus a ROM_LAT-deep side pipeline carrying the
    // pixel valid, whether anything was hit and which transparent key to
    // apply, so the tags line up with rom_data_i when it returns.
    logic                  fetch;
    logic [ROM_ADDR_W-1:0] rom_addr_q, rom_addr_d;
    rom_sel_e              rom_sel_q, rom_sel_d;
    logic [ROM_LAT:0]      validPipe_q, validPipe_d;
    logic [ROM_LAT:0]      hitPipe_q, hitPipe_d;
    logic [ROM_LAT:0]      tankPipe_q, tankPipe_d;

    assign fetch = pixel_valid_i && anyHit;

    always_comb begin
        rom_addr_d     = fetch ? winAddr : '0;
        rom_sel_d      = fetch ? layerRomSel(winIdx, active_q[winIdx].dir) : ROM_NONE;
        validPipe_d    = validPipe_q;
        hitPipe_d      = hitPipe_q;
        tankPipe_d     = tankPipe_q;
        validPipe_d[0] = pixel_valid_i;
        hitPipe_d[0]   = fetch;
        tankPipe_d[0]  = fetch && layerIsTank(winIdx);
        for (int i = 1; i <= ROM_LAT; i++) begin
            validPipe_d[i] = validPipe_q[i-1];
            hitPipe_d[i]   = hitPipe_q[i-1];
            tankPipe_d[i]  = tankPipe_q[i-1];
        end
    end

    // Colour resolve works directly on returning ROM data so the pixel
    // appears in the same cycle the ROM delivers it; the hold register
    // keeps VGA_* stable between valid pixels.
    logic [RGB_W-1:0] key;
    logic [RGB_W-1:0] pixelColour;
    logic [RGB_W-1:0] vgaHold_q, vgaHold_d;

    assign key         = tankPipe_q[ROM_LAT] ? KEY_TANK : KEY_OTHER;
    assign pixelColour = (!hitPipe_q[ROM_LAT] || (rom_data_i == key)) ? BG_COLOUR : rom_data_i;
    assign vgaHold_d   = validPipe_q[ROM_LAT] ? pixelColour : vgaHold_q;

    // Collision flags use the raw hit vector (before transparency). Clear
    // on frame_start first so a same-cycle overlap still sets the flag.
    // Assumes at least three layers (tanks and bullet present).
    logic collideT1_q, collideT1_d;
    logic collideT2_q, collideT2_d;

    always_comb begin
        collideT1_d = frame_start_i ? 1'b0 : collideT1_q;
        collideT2_d = frame_start_i ? 1'b0 : collideT2_q;
        if (pixel_valid_i && hit[0] && hit[2]) begin
            collideT1_d = 1'b1;
        end
        if (pixel_valid_i && hit[1] && hit[2]) begin
            collideT2_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rom_addr_q  <= '0;
            rom_sel_q   <= ROM_NONE;
            validPipe_q <= '0;
            hitPipe_q   <= '0;
            tankPipe_q  <= '0;
            vgaHold_q   <= '0;
            collideT1_q <= 1'b0;
            collideT2_q <= 1'b0;
        end else begin
            rom_addr_q  <= rom_addr_d;
            rom_sel_q   <= rom_sel_d;
            validPipe_q <= validPipe_d;
            hitPipe_q   <= hitPipe_d;
            tankPipe_q  <= tankPipe_d;
            vgaHold_q   <= vgaHold_d;
            collideT1_q <= collideT1_d;
            collideT2_q <= collideT2_d;
        end
    end

    assign rom_addr_o                  = rom_addr_q;
    assign rom_sel_o                   = rom_sel_q;
    assign out_valid_o                 = validPipe_q[ROM_LAT];
    assign {VGA_R_o, VGA_G_o, VGA_B_o} = vgaHold_d;
    assign collide_t1_o                = collideT1_q;
    assign collide_t2_o                = collideT2_q;

endmodule

// File: tb/tb_sprite_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sprite_fetch_sequencer
// Directed and randomized bench for sprite_fetch_sequencer. A behavioural
// model (layer table walked in priority order with plain arithmetic) predicts
// ROM requests, resolved pixels and collision flags every cycle.
// ---------------------------------------------------------------------------
module tb_sprite_fetch_sequencer;

    localparam int ROM_LAT = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frameStart = 1'b0;
    logic        pixelValid = 1'b0;
    logic [9:0]  drawX = '0;
    logic [9:0]  drawY = '0;
    logic        cfgWe = 1'b0;
    logic [2:0]  cfgLayer = '0;
    logic [9:0]  cfgX = '0;
    logic [9:0]  cfgY = '0;
    logic [1:0]  cfgDir = '0;
    logic        cfgEn = 1'b0;
    logic [18:0] romAddr;
    logic [2:0]  romSel;
    logic [23:0] romData = '0;
    logic        outValid;
    logic [7:0]  vgaR, vgaG, vgaB;
    logic        collideT1, collideT2;

    logic        romOverrideEn = 1'b0;
    logic [23:0] romOverride = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sprite_fetch_sequencer #(
        .NUM_LAYERS(8),
        .ROM_LAT   (ROM_LAT)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .frame_start_i(frameStart),
        .pixel_valid_i(pixelValid),
        .DrawX_i      (drawX),
        .DrawY_i      (drawY),
        .cfg_we_i     (cfgWe),
        .cfg_layer_i  (cfgLayer),
        .cfg_x_i      (cfgX),
        .cfg_y_i      (cfgY),
        .cfg_dir_i    (cfgDir),
        .cfg_en_i     (cfgEn),
        .rom_addr_o   (romAddr),
        .rom_sel_o    (romSel),
        .rom_data_i   (romData),
        .out_valid_o  (outValid),
        .VGA_R_o      (vgaR),
        .VGA_G_o      (vgaG),
        .VGA_B_o      (vgaB),
        .collide_t1_o (collideT1),
        .collide_t2_o (collideT2)
    );

    // Sprite ROM contents: every eighth address holds that ROM's
    // transparent key, the rest a hash of select and address.
    function automatic logic [23:0] romFunc(input int sel, input int addr);
        if ((addr % 8) == 0) begin
            return (sel < 4) ? 24'hFF0000 : 24'hFFFFFF;
        end
        return 24'(sel * 663987 + addr * 40503 + 1267611);
    endfunction

    // Synchronous ROM with one cycle of read latency.
    always @(posedge clk) begin
        romData <= romOverrideEn ? romOverride : romFunc(int'(romSel), int'(romAddr));
    end

    // Reference model state.
    typedef struct {
        bit en;
        int x;
        int y;
        int dir;
    } cfg_t;

    int   layerW [8] = '{32, 32, 16, 64, 16, 64, 16, 16};
    int   layerH [8] = '{32, 32, 16, 16, 64, 16, 64, 16};
    cfg_t shadowM [8];
    cfg_t activeM [8];

    bit          e1Valid, e1Hit, e1Tank;
    int          e1Sel, e1Addr;
    bit          e2Valid, e2Hit, e2Tank;
    int          e2Sel, e2Addr;
    bit          mC1, mC2;
    logic [23:0] lastVga;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic resetModel();
        for (int l = 0; l < 8; l++) begin
            shadowM[l] = '{en: 1'b0, x: 0, y: 0, dir: 0};
            activeM[l] = '{en: 1'b0, x: 0, y: 0, dir: 0};
        end
        e1Valid = 0; e1Hit = 0; e1Tank = 0; e1Sel = 7; e1Addr = 0;
        e2Valid = 0; e2Hit = 0; e2Tank = 0; e2Sel = 7; e2Addr = 0;
        mC1 = 0; mC2 = 0;
        lastVga = '0;
    endtask

    // Compares all DUT outputs against the model at a negedge.
    task automatic checkOutput();
        logic [23:0] data;
        logic [23:0] key;
        if (e2Valid) begin
            data    = romOverrideEn ? romOverride : romFunc(e2Sel, e2Addr);
            key     = e2Tank ? 24'hFF0000 : 24'hFFFFFF;
            lastVga = (!e2Hit || data == key) ? 24'hFFFFFF : data;
        end
        checkVal("romSel",    32'(romSel),   32'(e1Sel));
        checkVal("romAddr",   32'(romAddr),  32'(e1Addr));
        checkVal("outValid",  32'(outValid), 32'(e2Valid));
        checkVal("vga",       32'({vgaR, vgaG, vgaB}), 32'(lastVga));
        checkVal("collideT1", 32'(collideT1), 32'(mC1));
        checkVal("collideT2", 32'(collideT2), 32'(mC2));
    endtask

    // One clock with the inputs currently set; the model advances alongside.
    task automatic applyStimulus();
        bit h [8];
        int win;
        int winAddr;
        int rx, ry;
        e2Valid = e1Valid; e2Hit = e1Hit; e2Tank = e1Tank; e2Sel = e1Sel; e2Addr = e1Addr;
        win = -1;
        winAddr = 0;
        for (int l = 0; l < 8; l++) begin
            rx   = (int'(drawX) - activeM[l].x) & 1023;
            ry   = (int'(drawY) - activeM[l].y) & 1023;
            h[l] = activeM[l].en && (rx < layerW[l]) && (ry < layerH[l]);
            if (h[l] && win < 0) begin
                win     = l;
                winAddr = rx + ry * layerW[l];
            end
        end
        e1Valid = pixelValid;
        if (pixelValid && win >= 0) begin
            e1Hit  = 1;
            e1Tank = (win < 2);
            if (win < 2)                   e1Sel = activeM[win].dir;
            else if (win == 2 || win == 7) e1Sel = 4;
            else if (win == 3 || win == 5) e1Sel = 5;
            else                           e1Sel = 6;
            e1Addr = winAddr;
        end else begin
            e1Hit = 0; e1Tank = 0; e1Sel = 7; e1Addr = 0;
        end
        if (frameStart) begin
            mC1 = 0;
            mC2 = 0;
        end
        if (pixelValid && h[0] && h[2]) mC1 = 1;
        if (pixelValid && h[1] && h[2]) mC2 = 1;
        if (cfgWe) begin
            shadowM[cfgLayer] = '{en: cfgEn, x: int'(cfgX), y: int'(cfgY), dir: int'(cfgDir)};
        end
        if (frameStart) begin
            for (int l = 0; l < 8; l++) activeM[l] = shadowM[l];
        end
        @(posedge clk);
        @(negedge clk);
        checkOutput();
        frameStart = 1'b0;
        cfgWe      = 1'b0;
        pixelValid = 1'b0;
    endtask

    task automatic applyReset();
        rst = 1'b1;
        #1;
        checkVal("rstOutValidNow", 32'(outValid), 32'd0);
        resetModel();
        checkOutput();
        @(negedge clk);
        checkOutput();
        rst = 1'b0;
    endtask

    task automatic writeCfg(input int layer, input int x, input int y, input int dir, input bit en);
        cfgWe = 1'b1; cfgLayer = 3'(layer); cfgX = 10'(x); cfgY = 10'(y);
        cfgDir = 2'(dir); cfgEn = en;
        applyStimulus();
    endtask

    task automatic commit();
        frameStart = 1'b1;
        applyStimulus();
    endtask

    task automatic drawPixel(input int x, input int y);
        pixelValid = 1'b1; drawX = 10'(x); drawY = 10'(y);
        applyStimulus();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    function automatic logic [9:0] nearCoord();
        if ($urandom_range(0, 9) == 0) return 10'($urandom_range(0, 1023));
        return 10'(90 + $urandom_range(0, 60));
    endfunction

    initial begin
        resetModel();
        @(negedge clk);
        applyReset();
        idle(1);

        // Tank1 at (100,100) facing right, committed.
        writeCfg(0, 100, 100, 1, 1);
        drawPixel(105, 102);
        checkVal("uncommittedSel", 32'(romSel), 32'd7);
        commit();
        drawPixel(105, 102);
        checkVal("tankSel", 32'(romSel), 32'd1);
        checkVal("tankAddr", 32'(romAddr), 32'd69);
        checkVal("tankValidEarly", 32'(outValid), 32'd0);
        idle(1);
        checkVal("tankValidLate", 32'(outValid), 32'd1);

        // Transparent key versus opaque colour for a tank pixel.
        romOverrideEn = 1'b1;
        romOverride   = 24'hFF0000;
        drawPixel(105, 102);
        idle(1);
        checkVal("tankKeyBg", 32'({vgaR, vgaG, vgaB}), 32'h00FFFFFF);
        romOverride = 24'h123456;
        drawPixel(105, 102);
        idle(1);
        checkVal("tankOpaque", 32'({vgaR, vgaG, vgaB}), 32'h00123456);
        idle(2);
        checkVal("vgaHold", 32'({vgaR, vgaG, vgaB}), 32'h00123456);
        romOverrideEn = 1'b0;

        // Bullet over tank1: tank wins, collision is sticky within frame.
        writeCfg(2, 100, 100, 0, 1);
        commit();
        drawPixel(101, 101);
        checkVal("collideSel", 32'(romSel), 32'd1);
        checkVal("collideSet", 32'(collideT1), 32'd1);
        idle(3);
        checkVal("collideHeld", 32'(collideT1), 32'd1);
        commit();
        checkVal("collideCleared", 32'(collideT1), 32'd0);
        frameStart = 1'b1;
        drawPixel(101, 101);
        checkVal("collideSetWins", 32'(collideT1), 32'd1);

        // Shadow write without commit leaves the old origin active.
        writeCfg(0, 200, 100, 1, 1);
        drawPixel(105, 102);
        checkVal("shadowOldSel", 32'(romSel), 32'd1);
        commit();
        drawPixel(205, 102);
        checkVal("shadowNewAddr", 32'(romAddr), 32'd69);
        drawPixel(105, 102);
        checkVal("bulletSel", 32'(romSel), 32'd4);
        checkVal("bulletAddr", 32'(romAddr), 32'd37);

        // Write coincident with frame_start: pixel sees old, commit sees new.
        cfgWe = 1'b1; cfgLayer = 3'd2; cfgX = 10'd300; cfgY = 10'd100; cfgDir = 2'd0; cfgEn = 1'b1;
        frameStart = 1'b1;
        drawPixel(105, 102);
        checkVal("fwdOldSel", 32'(romSel), 32'd4);
        drawPixel(305, 102);
        checkVal("fwdNewSel", 32'(romSel), 32'd4);

        // Sprite near the right edge does not wrap onto the left.
        writeCfg(0, 0, 0, 0, 0);
        writeCfg(2, 630, 0, 0, 1);
        commit();
        drawPixel(5, 5);
        checkVal("noWrapSel", 32'(romSel), 32'd7);
        checkVal("noWrapAddr", 32'(romAddr), 32'd0);
        drawPixel(640, 5);
        checkVal("edgeAddr", 32'(romAddr), 32'd90);

        // Reset with two pixels in flight.
        drawPixel(640, 5);
        pixelValid = 1'b1; drawX = 10'd641; drawY = 10'd5;
        applyStimulus();
        applyReset();
        idle(4);
        checkVal("postRstValid", 32'(outValid), 32'd0);

        // Randomized traffic clustered so sprites overlap frequently.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 15) < 3) begin
                cfgWe    = 1'b1;
                cfgLayer = 3'($urandom_range(0, 7));
                cfgX     = nearCoord();
                cfgY     = nearCoord();
                cfgDir   = 2'($urandom_range(0, 3));
                cfgEn    = ($urandom_range(0, 4) != 0);
            end
            if ($urandom_range(0, 11) == 0) frameStart = 1'b1;
            if ($urandom_range(0, 3) != 0) begin
                pixelValid = 1'b1;
                drawX      = nearCoord();
                drawY      = nearCoord();
            end
            applyStimulus();
        end
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
